scl_clk_gen: RTL
================

# scl_clk_gen

Parametrised, programmable SCL clock generator for the I2C master datapath. Successor to the fixed-ratio divider: runtime half-period from a register input, clean start/stop under an enable, slave clock-stretching via SCL readback, a stretch timeout, and mid-phase strobes for the shifter (drive SDA at mid-low, sample SDA at mid-high). One instance sits between the bus controller FSM and the open-drain SCL pad.

## Interface
- CNT_W, 16: width of the half-period value and phase counter.
- STRETCH_MAX, 1024: maximum stretched cycles per high phase; 0 disables the timeout.
- TO_W, 16: width of the stretch counter; must satisfy 2^TO_W > STRETCH_MAX.

- clk_in  in  1  system clock; one clock domain.
- resetN  in  1  reset; asynchronous, active-low.
- en  in  1  run request; level-sensitive.
- div  in  CNT_W  half-period in clk_in cycles; values 0 and 1 are treated as 2.
- scl_in  in  1  SCL readback, already synchronous to clk_in.
- clk_out  out  1  SCL drive level; 1 = released/high.
- scl_negedge  out  1  one-cycle strobe, first cycle of the low phase.
- scl_posedge  out  1  one-cycle strobe, first cycle of the high phase with scl_in=1.
- scl_mid_low  out  1  one-cycle strobe at low-phase count H>>1.
- scl_mid_high  out  1  one-cycle strobe at high-phase count H>>1, qualified by scl_in.
- busy  out  1  1 in LOW or HIGH.
- stretching  out  1  1 in HIGH while scl_in=0.
- stretch_to  out  1  one-cycle pulse on stretch timeout.

## Operation
- States: IDLE, LOW, HIGH. Registers: state, cnt (CNT_W), h_reg (CNT_W), scnt (TO_W), clk_out, stretch_to.
- Reset: state=IDLE, cnt=0, scnt=0, h_reg=2, clk_out=1, stretch_to=0. All strobes, busy and stretching 0.
- h_reg loads max(div,2) on every entry to LOW, from IDLE or HIGH. A div change mid-phase takes effect at the next low phase.
- IDLE: clk_out=1. en=1 -> LOW, cnt=0.
- LOW: clk_out=0. cnt increments each cycle. At cnt=h_reg-1 -> HIGH, cnt=0, scnt=0.
- HIGH: clk_out=1.
  - scl_in=1: cnt increments.
  - scl_in=0: cnt holds and scnt increments.
  - At cnt=h_reg-1 with scl_in=1: if en=1 -> LOW (cnt=0); else -> IDLE.
- en deassertion never truncates a period. The block always finishes the current high phase, so SCL stops high.
- Timeout (STRETCH_MAX>0): in HIGH with scl_in=0 and scnt=STRETCH_MAX-1 -> IDLE, cnt=0, stretch_to=1 for exactly the next cycle.
- Decodes (combinational from registered state):
  - scl_negedge = LOW && cnt==0.
  - scl_posedge = HIGH && cnt==0 && scl_in.
  - scl_mid_low = LOW && cnt==h_reg>>1.
  - scl_mid_high = HIGH && cnt==h_reg>>1 && scl_in.
  - stretching = HIGH && !scl_in.
- Because cnt holds while scl_in=0, each strobe fires exactly once per phase.

## Timing
- Start latency: en sampled 1 at edge k in IDLE. clk_out=0 and scl_negedge=1 in the cycle after edge k.
- Unstretched (scl_in follows clk_out): low = H cycles, high = H cycles, period = 2H, duty 50%.
- A stretch of S cycles lengthens the high phase to H+S. scl_posedge is delayed to the first cycle scl_in=1.
- Stop: IDLE is entered at the edge ending the last high cycle. clk_out stays 1 and busy drops at that edge.
- en re-asserted in the final HIGH cycle: the block continues straight into LOW with no IDLE gap.
- Reset mid-operation: immediate asynchronous return to reset values, including clk_out=1. No strobe fires during or after reset until en restarts.

## Test plan
- div=4, en=1, scl_in=clk_out:
  - clk_out follows 4 low / 4 high, period 8.
  - scl_negedge in low cycle 1, scl_mid_low in low cycle 3 (cnt=2).
  - scl_posedge in high cycle 1, scl_mid_high in high cycle 3.
- div=0 and div=1: each gives period 4 (2 low / 2 high). div 4->10 written mid-HIGH: the next low phase is 10 cycles.
- Stretch: div=4, scl_in forced 0 for 5 cycles at the start of HIGH:
  - stretching=1 for 5 cycles; high phase 9 cycles.
  - scl_posedge occurs once, on the 6th high cycle.
- Timeout: STRETCH_MAX=16, scl_in held 0 in HIGH:
  - after 16 stretched cycles, state=IDLE and clk_out=1.
  - stretch_to pulses for 1 cycle; busy=0.
- en dropped at low cycle 2 (div=4): the period completes (4 low, 4 high), then IDLE with clk_out=1. No further scl_negedge.
- resetN asserted at high cycle 2: clk_out=1, busy=0, all strobes 0 immediately. After release with en=1, the first scl_negedge comes 1 cycle later.

Source files
------------

// File: rtl/scl_clk_gen.sv
// -----------------------------------------------------------------------------
// scl_clk_gen
//
// Programmable SCL clock generator for the I2C master datapath. Produces the
// open-drain SCL drive level with a runtime half-period, honours slave clock
// stretching through SCL readback, aborts a stretch that exceeds STRETCH_MAX
// cycles, and emits mid-phase strobes for the SDA shifter.
//
// Parameters
//   CNT_W        width of the half-period input and phase counter
//   STRETCH_MAX  max stretched cycles per high phase (0 = no timeout)
//   TO_W         width of the stretch counter (2**TO_W > STRETCH_MAX)
//
// Ports
//   clk_in        in   system clock (single domain)
//   resetN        in   asynchronous active-low reset
//   en            in   run request, level-sensitive
//   div           in   half-period in clk_in cycles (0 and 1 behave as 2)
//   scl_in        in   SCL readback, already synchronous to clk_in
//   clk_out       out  SCL drive level, 1 = released/high
//   scl_negedge   out  strobe, first cycle of the low phase
//   scl_posedge   out  strobe, first cycle of the high phase seen high
//   scl_mid_low   out  strobe, middle of the low phase (drive SDA)
//   scl_mid_high  out  strobe, middle of the high phase (sample SDA)
//   busy          out  generator is running a low or high phase
//   stretching    out  high phase held low by a slave
//   stretch_to    out  one-cycle pulse after a stretch timeout
// -----------------------------------------------------------------------------
module scl_clk_gen #(
  parameter int CNT_W       = 16,
  parameter int STRETCH_MAX = 1024,
  parameter int TO_W        = 16
) (
  input  logic             clk_in,
  input  logic             resetN,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  input  logic             scl_in,
  output logic             clk_out,
  output logic             scl_negedge,
  output logic             scl_posedge,
  output logic             scl_mid_low,
  output logic             scl_mid_high,
  output logic             busy,
  output logic             stretching,
  output logic             stretch_to
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  // Timeout compare value; a zero STRETCH_MAX disables the timeout entirely.
  localparam bit             TO_EN     = (STRETCH_MAX > 0);
  localparam logic [TO_W-1:0] SCNT_LAST = TO_EN ? TO_W'(STRETCH_MAX - 1) : '0;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_h, w_h_nxt;
  logic [TO_W-1:0]  r_scnt, w_scnt_nxt;
  logic             r_clk_out;
  logic             r_stretch_to, w_stretch_to_nxt;

  logic [CNT_W-1:0] w_h_div;   // clamped half-period from the register input
  logic [CNT_W-1:0] w_h_last;  // last count of a phase
  logic [CNT_W-1:0] w_h_mid;   // mid-phase count
  logic             w_phase_end;
  logic             w_timeout;

  // Half-periods below 2 would collapse a phase to a single cycle and make
  // the mid and edge strobes coincide, so they are clamped to 2.
  assign w_h_div     = (div < CNT_W'(2)) ? CNT_W'(2) : div;
  assign w_h_last    = r_h - CNT_W'(1);
  assign w_h_mid     = r_h >> 1;
  assign w_phase_end = (r_cnt == w_h_last);
  assign w_timeout   = TO_EN && (r_scnt == SCNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_h_nxt          = r_h;
    w_scnt_nxt       = r_scnt;
    w_stretch_to_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
          w_h_nxt     = w_h_div;
        end
      end

      S_LOW: begin
        if (w_phase_end) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
          w_scnt_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_HIGH: begin
        if (scl_in) begin
          // The high phase always runs to completion; en only decides
          // whether another period follows.
          if (w_phase_end) begin
            w_cnt_nxt = '0;
            if (en) begin
              w_state_nxt = S_LOW;
              w_h_nxt     = w_h_div;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          // A slave holds SCL low: freeze the phase count so every strobe
          // still fires exactly once, and count the stretch instead.
          if (w_timeout) begin
            w_state_nxt      = S_IDLE;
            w_cnt_nxt        = '0;
            w_stretch_to_nxt = 1'b1;
          end else begin
            w_scnt_nxt = r_scnt + TO_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge resetN) begin
    if (!resetN) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_h          <= CNT_W'(2);
      r_scnt       <= '0;
      r_clk_out    <= 1'b1;
      r_stretch_to <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_h          <= w_h_nxt;
      r_scnt       <= w_scnt_nxt;
      // SCL is driven from a flop so the pad never sees decode glitches.
      r_clk_out    <= (w_state_nxt != S_LOW);
      r_stretch_to <= w_stretch_to_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decodes
  // ---------------------------------------------------------------------------
  assign clk_out      = r_clk_out;
  assign stretch_to   = r_stretch_to;
  assign busy         = (r_state != S_IDLE);
  assign stretching   = (r_state == S_HIGH) && !scl_in;
  assign scl_negedge  = (r_state == S_LOW)  && (r_cnt == '0);
  assign scl_posedge  = (r_state == S_HIGH) && (r_cnt == '0) && scl_in;
  assign scl_mid_low  = (r_state == S_LOW)  && (r_cnt == w_h_mid);
  assign scl_mid_high = (r_state == S_HIGH) && (r_cnt == w_h_mid) && scl_in;

endmodule
